ssd1306_frame_streamer: RTL and testbench

Owns the SSD1306 128x64 OLED over a 4-wire write-only SPI link. After a power-up reset it sends a fixed init command sequence. It then streams frames continuously: for each byte it presents `pixel_index` to the pattern source, samples the returned `pattern_byte`, and shifts it out to the panel. It also advances `frame_number`, which paces game logic downstream.

---
 rtl/ssd1306_frame_streamer_pkg.sv | 32 +++
 rtl/ssd1306_frame_streamer_if.sv | 27 ++
 rtl/ssd1306_frame_streamer_spi_byte_tx.sv | 88 ++++++++
 rtl/ssd1306_frame_streamer.sv | 158 +++++++++++++++
 tb/tb_ssd1306_frame_streamer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ssd1306_frame_streamer_pkg.sv
// Purpose: shared constants for the SSD1306 streamer: sequencer states, command ROMs, panel geometry.
// Latency: none (constants only).
// Backpressure: n/a.
package oled_pkg;

    localparam int OLED_COLS  = 128;
    localparam int OLED_PAGES = 8;
    localparam int OLED_BYTES = OLED_COLS * OLED_PAGES;
    localparam int PIX_W      = 10;

    // Sequencer states, kept as plain constants so older tools see a fixed 3-bit encoding.
    typedef logic [2:0] stateT;
    localparam stateT ST_RST_HOLD = 3'd0;
    localparam stateT ST_PWR_WAIT = 3'd1;
    localparam stateT ST_INIT     = 3'd2;
    localparam stateT ST_ADDR     = 3'd3;
    localparam stateT ST_DATA     = 3'd4;
    localparam stateT ST_GAP      = 3'd5;

    // Display off, horizontal addressing, charge pump on, segment/COM remap, display on.
    localparam int INIT_LEN = 8;
    localparam logic [7:0] INIT_ROM [0:7] = '{
        8'hAE, 8'h20, 8'h00, 8'h8D, 8'h14, 8'hA1, 8'hC8, 8'hAF
    };

    // Column window 0..127 and page window 0..7, re-sent each frame to re-home the panel pointer.
    localparam int ADDR_LEN = 6;
    localparam logic [7:0] ADDR_ROM [0:5] = '{
        8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
    };

endpackage

// File: rtl/ssd1306_frame_streamer_if.sv
// Purpose: bundles the pattern-source handshake and the panel SPI pins of the frame streamer.
// Latency: none (wiring only).
// Backpressure: none; the streamer paces the source, the panel never stalls.
interface ssd1306_frame_streamer_if;

    logic [7:0]               pattern_byte;
    logic [oled_pkg::PIX_W-1:0] pixel_index;
    logic [7:0]               frame_number;
    logic                     oled_sclk;
    logic                     oled_sdin;
    logic                     oled_cs_n;
    logic                     oled_dc;
    logic                     oled_res_n;

    modport master (
        input  pattern_byte,
        output pixel_index, frame_number,
        output oled_sclk, oled_sdin, oled_cs_n, oled_dc, oled_res_n
    );

    modport slave (
        output pattern_byte,
        input  pixel_index, frame_number,
        input  oled_sclk, oled_sdin, oled_cs_n, oled_dc, oled_res_n
    );

endinterface

// File: rtl/ssd1306_frame_streamer_spi_byte_tx.sv
// Purpose: shifts one byte out on a mode-0 SPI link in setup / shift / release phases.
// Latency: 16*CLK_DIV+2 cycles per byte; start accepted in idle or in the release cycle.
// Backpressure: ready low while a byte is in flight; done pulses in the last shift cycle.
module spi_byte_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txByte,
    input  logic       dc,
    input  logic       start,
    output logic       ready,
    output logic       done,
    output logic       sclk,
    output logic       sdin,
    output logic       csN,
    output logic       dcOut
);

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_SETUP = 2'd1;
    localparam logic [1:0] PH_SHIFT = 2'd2;
    localparam logic [1:0] PH_REL   = 2'd3;

    logic [1:0] phase;
    logic [7:0] divCnt;
    logic [3:0] halfCnt;
    logic [7:0] shReg;
    logic       halfEnd;

    assign halfEnd = (divCnt == 8'(CLK_DIV - 1));
    assign ready   = (phase == PH_IDLE) || (phase == PH_REL);
    assign done    = (phase == PH_SHIFT) && halfEnd && (halfCnt == 4'd15);

    // Byte sequencer: 16 SCLK half-periods, data advanced only on falling edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= PH_IDLE;
            divCnt  <= '0;
            halfCnt <= '0;
            shReg   <= '0;
            sclk    <= 1'b0;
            sdin    <= 1'b0;
            csN     <= 1'b1;
            dcOut   <= 1'b0;
        end else begin
            case (phase)
                PH_IDLE, PH_REL: begin
                    if (start) begin
                        phase <= PH_SETUP;
                        shReg <= txByte;
                        dcOut <= dc;
                        sdin  <= txByte[7];
                        csN   <= 1'b0;
                        sclk  <= 1'b0;
                    end else begin
                        phase <= PH_IDLE;
                    end
                end
                PH_SETUP: begin
                    phase   <= PH_SHIFT;
                    divCnt  <= '0;
                    halfCnt <= '0;
                end
                default: begin
                    if (halfEnd) begin
                        divCnt <= '0;
                        if (halfCnt == 4'd15) begin
                            phase <= PH_REL;
                            csN   <= 1'b1;
                            sclk  <= 1'b0;
                        end else begin
                            halfCnt <= halfCnt + 4'd1;
                            sclk    <= ~sclk;
                            if (sclk) begin
                                shReg <= {shReg[6:0], 1'b0};
                                sdin  <= shReg[6];
                            end
                        end
                    end else begin
                        divCnt <= divCnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ssd1306_frame_streamer.sv
// Purpose: resets and initialises an SSD1306 128x64 panel, then streams frames from a pattern source.
// Latency: pattern_byte sampled 1 cycle after pixel_index settles; frame = 1030 byte slots (+gap).
// Backpressure: none; free-running. Optional inter-frame gap with OLED_FRAME_GAP_EN.
module ssd1306_frame_streamer #(
    parameter int unsigned CLK_DIV          = 4,
    parameter int unsigned RESET_CYCLES     = 270,
    parameter int unsigned POWERUP_CYCLES   = 2700,
    parameter int unsigned FRAME_GAP_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    ssd1306_frame_streamer_if.master  bus
);

    import oled_pkg::*;

`ifdef OLED_FRAME_GAP_EN
    localparam stateT FRAME_NEXT = (FRAME_GAP_CYCLES != 0) ? ST_GAP : ST_ADDR;
`else
    localparam stateT FRAME_NEXT = ST_ADDR;
`endif

    stateT            state;
    logic [15:0]      waitCnt;
    logic [2:0]       romIdx;
    logic [PIX_W-1:0] pixelIndex;
    logic [7:0]       frameNumber;
    logic             resN;

    logic             sending;
    logic             txReady;
    logic             txDone;
    logic             txStart;
    logic [7:0]       txByte;
    logic             txDc;

    // Select the byte for the current state; ROM index / pixel index already point at it.
    always_comb begin
        txByte  = 8'h00;
        txDc    = 1'b0;
        sending = 1'b0;
        case (state)
            ST_INIT: begin
                txByte  = INIT_ROM[romIdx];
                sending = 1'b1;
            end
            ST_ADDR: begin
                txByte  = ADDR_ROM[romIdx];
                sending = 1'b1;
            end
            ST_DATA: begin
                txByte  = bus.pattern_byte;
                txDc    = 1'b1;
                sending = 1'b1;
            end
            default: ;
        endcase
    end

    assign txStart = sending && txReady;

    // Sequencer: advances indices on the last shift cycle so they are settled through release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RST_HOLD;
            waitCnt     <= '0;
            romIdx      <= '0;
            pixelIndex  <= '0;
            frameNumber <= '0;
            resN        <= 1'b0;
        end else begin
            case (state)
                ST_RST_HOLD: begin
                    if (waitCnt == 16'(RESET_CYCLES - 1)) begin
                        state   <= ST_PWR_WAIT;
                        waitCnt <= '0;
                        resN    <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 16'd1;
                    end
                end
                ST_PWR_WAIT: begin
                    if (waitCnt == 16'(POWERUP_CYCLES - 1)) begin
                        state   <= ST_INIT;
                        waitCnt <= '0;
                        romIdx  <= '0;
                    end else begin
                        waitCnt <= waitCnt + 16'd1;
                    end
                end
                ST_INIT: begin
                    if (txDone) begin
                        if (romIdx == 3'(INIT_LEN - 1)) begin
                            romIdx <= '0;
                            state  <= ST_ADDR;
                        end else begin
                            romIdx <= romIdx + 3'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (txDone) begin
                        if (romIdx == 3'(ADDR_LEN - 1)) begin
                            romIdx <= '0;
                            state  <= ST_DATA;
                        end else begin
                            romIdx <= romIdx + 3'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (txDone) begin
                        if (pixelIndex == PIX_W'(OLED_BYTES - 1)) begin
                            pixelIndex  <= '0;
                            frameNumber <= frameNumber + 8'd1;
                            waitCnt     <= '0;
                            state       <= FRAME_NEXT;
                        end else begin
                            pixelIndex <= pixelIndex + PIX_W'(1);
                        end
                    end
                end
`ifdef OLED_FRAME_GAP_EN
                ST_GAP: begin
                    if (waitCnt == 16'(FRAME_GAP_CYCLES - 1)) begin
                        waitCnt <= '0;
                        state   <= ST_ADDR;
                    end else begin
                        waitCnt <= waitCnt + 16'd1;
                    end
                end
`endif
                default: state <= ST_RST_HOLD;
            endcase
        end
    end

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk    (clk),
        .rst    (reset),
        .txByte (txByte),
        .dc     (txDc),
        .start  (txStart),
        .ready  (txReady),
        .done   (txDone),
        .sclk   (bus.oled_sclk),
        .sdin   (bus.oled_sdin),
        .csN    (bus.oled_cs_n),
        .dcOut  (bus.oled_dc)
    );

    assign bus.pixel_index  = pixelIndex;
    assign bus.frame_number = frameNumber;
    assign bus.oled_res_n   = resN;

endmodule

// File: tb/tb_ssd1306_frame_streamer.sv
// Purpose: self-checking bench for ssd1306_frame_streamer with an SPI decoder and XOR pattern source.
// Latency: uses CLK_DIV=1 so each byte slot is 18 cycles and a frame is 18540 cycles.
// Backpressure: n/a; every wait on the DUT is bounded.
module tb_ssd1306_frame_streamer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ssd1306_frame_streamer_if bus();

    assign bus.pattern_byte = bus.pixel_index[7:0] ^ 8'h5A;

    ssd1306_frame_streamer #(
        .CLK_DIV          (1),
        .RESET_CYCLES     (6),
        .POWERUP_CYCLES   (10),
        .FRAME_GAP_CYCLES (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct { logic dc; logic [7:0] val; } spiByteT;
    typedef struct { int setupPix; int prevPix; } pixRecT;
    typedef struct { string name; int idx; logic dc; logic [7:0] val; } vecT;

    spiByteT byteLog[$];
    pixRecT  pixLog[$];
    vecT     vecs[$];

    int checkCnt = 0;
    int passCnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checkCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    endtask

    // SPI decoder: mode 0, MSB first, sample on SCLK rising edges while selected.
    logic [2:0] bitCnt;
    logic [6:0] rxSh;
    always @(posedge bus.oled_sclk or posedge reset) begin
        if (reset) begin
            bitCnt <= 3'd0;
            rxSh   <= 7'd0;
        end else if (!bus.oled_cs_n) begin
            if (bitCnt == 3'd7) begin
                byteLog.push_back('{bus.oled_dc, {rxSh, bus.oled_sdin}});
                bitCnt <= 3'd0;
            end else begin
                rxSh   <= {rxSh[5:0], bus.oled_sdin};
                bitCnt <= bitCnt + 3'd1;
            end
        end
    end

    // Records pixel_index in each data setup cycle and in the cycle before it.
    logic prevCs  = 1'b1;
    int   prevPix = 0;
    always @(negedge clk) begin
        if (!reset && prevCs && !bus.oled_cs_n && bus.oled_dc)
            pixLog.push_back('{int'(bus.pixel_index), prevPix});
        prevCs  <= bus.oled_cs_n;
        prevPix <= int'(bus.pixel_index);
    end

    int  n;
    int  lastPix;
    int  lastFrame;
    int  mark;
    bit  ok;
    logic [7:0] initExp [14];

    initial begin
        initExp = '{8'hAE, 8'h20, 8'h00, 8'h8D, 8'h14, 8'hA1, 8'hC8, 8'hAF,
                    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
        for (int i = 0; i < 14; i++)
            vecs.push_back('{$sformatf("cmd%0d", i), i, 1'b0, initExp[i]});
        vecs.push_back('{"data0",     14,   1'b1, 8'h5A});
        vecs.push_back('{"data300",   314,  1'b1, 8'h76});
        vecs.push_back('{"data1023",  1037, 1'b1, 8'hA5});
        for (int i = 0; i < 6; i++)
            vecs.push_back('{$sformatf("addr_f1_%0d", i), 1038 + i, 1'b0, initExp[8 + i]});

        // Reset values
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_res_n", int'(bus.oled_res_n), 0);
        chk("rst_cs_n",  int'(bus.oled_cs_n), 1);
        chk("rst_sclk",  int'(bus.oled_sclk), 0);
        chk("rst_sdin",  int'(bus.oled_sdin), 0);
        chk("rst_dc",    int'(bus.oled_dc), 0);
        chk("rst_pix",   int'(bus.pixel_index), 0);
        chk("rst_frame", int'(bus.frame_number), 0);

        // Panel reset hold length
        @(posedge clk);
        #1 reset = 1'b0;
        n = 0;
        while (bus.oled_res_n !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("res_n_rise_cycles", n, 6);

        // End of frame 0: pixel wrap and frame increment in the same cycle
        lastPix   = int'(bus.pixel_index);
        lastFrame = int'(bus.frame_number);
        ok = 1'b0;
        for (int i = 0; i < 25000 && !ok; i++) begin
            @(negedge clk);
            if (int'(bus.frame_number) != lastFrame) ok = 1'b1;
            else lastPix = int'(bus.pixel_index);
        end
        chk("wrap0_seen", int'(ok), 1);
        chk("wrap0_prev_pix", lastPix, 1023);
        chk("wrap0_pix", int'(bus.pixel_index), 0);
        chk("wrap0_frame", int'(bus.frame_number), 1);

        // Decoded byte stream against the vector table
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (byteLog.size() >= 1044) ok = 1'b1;
        end
        chk("log_filled", int'(ok), 1);
        foreach (vecs[i]) begin
            if (vecs[i].idx < byteLog.size()) begin
                chk({vecs[i].name, "_val"}, int'(byteLog[vecs[i].idx].val), int'(vecs[i].val));
                chk({vecs[i].name, "_dc"},  int'(byteLog[vecs[i].idx].dc),  int'(vecs[i].dc));
            end else begin
                chk({vecs[i].name, "_present"}, byteLog.size(), vecs[i].idx + 1);
            end
        end

        // pixel_index at the sample point of data bytes 0 and 300
        chk("pix_log_size", int'(pixLog.size() > 300), 1);
        if (pixLog.size() > 300) begin
            chk("pix0_setup",   pixLog[0].setupPix, 0);
            chk("pix0_prev",    pixLog[0].prevPix, 0);
            chk("pix300_setup", pixLog[300].setupPix, 300);
            chk("pix300_prev",  pixLog[300].prevPix, 300);
        end

        // frame_number wrap 255 -> 0
        ok = 1'b0;
        for (int i = 0; i < 25000 && !ok; i++) begin
            @(negedge clk);
            if (bus.pixel_index == 10'd100) ok = 1'b1;
        end
        chk("reach_pix100", int'(ok), 1);
        force dut.frameNumber = 8'd255;
        @(negedge clk);
        release dut.frameNumber;
        @(negedge clk);
        chk("frame_preload", int'(bus.frame_number), 255);
        ok = 1'b0;
        for (int i = 0; i < 25000 && !ok; i++) begin
            @(negedge clk);
            if (bus.frame_number != 8'd255) ok = 1'b1;
        end
        chk("wrap255_seen", int'(ok), 1);
        chk("wrap255_frame", int'(bus.frame_number), 0);
        chk("wrap255_pix", int'(bus.pixel_index), 0);

        // Reset during bit 3 of data byte 10
        ok = 1'b0;
        for (int i = 0; i < 25000 && !ok; i++) begin
            @(negedge clk);
            if (bus.pixel_index == 10'd10 && !bus.oled_cs_n && bus.oled_dc && bitCnt == 3'd3)
                ok = 1'b1;
        end
        chk("reach_byte10_bit3", int'(ok), 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_cs_n",  int'(bus.oled_cs_n), 1);
        chk("midrst_sclk",  int'(bus.oled_sclk), 0);
        chk("midrst_res_n", int'(bus.oled_res_n), 0);
        chk("midrst_frame", int'(bus.frame_number), 0);
        repeat (3) @(posedge clk);
        mark = byteLog.size();
        #1 reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (byteLog.size() >= mark + 2) ok = 1'b1;
        end
        chk("restart_bytes", int'(ok), 1);
        if (ok) begin
            chk("restart_b0_val", int'(byteLog[mark].val), 8'hAE);
            chk("restart_b0_dc",  int'(byteLog[mark].dc), 0);
            chk("restart_b1_val", int'(byteLog[mark + 1].val), 8'h20);
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
